// File: rtl/tx_enc_pkg.sv
// Shared definitions for the SUMP transmit encoder:
// FSM states, ID string, metadata key codes and protocol version.
package tx_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ID,
        ST_META,
        ST_SMPL
    } state_e;

    localparam logic [4:0] ID_LAST   = 5'd3;
    localparam logic [4:0] META_LAST = 5'd19;

    localparam logic [7:0] ID_B0 = 8'h31;
    localparam logic [7:0] ID_B1 = 8'h41;
    localparam logic [7:0] ID_B2 = 8'h4C;
    localparam logic [7:0] ID_B3 = 8'h53;

    localparam logic [7:0] KEY_NAME     = 8'h01;
    localparam logic [7:0] KEY_PROBES   = 8'h20;
    localparam logic [7:0] KEY_SMPL_MEM = 8'h21;
    localparam logic [7:0] KEY_PROTO    = 8'h41;
    localparam logic [7:0] KEY_END      = 8'h00;

    localparam logic [7:0] PROTO_VER  = 8'h02;
    localparam logic [7:0] NUM_PROBES = 8'd32;

    function automatic logic [7:0] id_byte(input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0: b = ID_B0;
            2'd1: b = ID_B1;
            2'd2: b = ID_B2;
            2'd3: b = ID_B3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tx_enc_meta_rom.sv
// Metadata block lookup: byte index -> byte.
// Indices past the end of the block read as 0x00.
module meta_rom
    import tx_enc_pkg::*;
#(
    parameter int MEM_DEPTH = 4096
) (
    input  logic [4:0] idx_i,
    output logic [7:0] dat_o
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

    // Table of the 20-byte metadata block; size field is big-endian
    always_comb begin
        dat_o = 8'h00;
        case (idx_i)
            5'd0:  dat_o = KEY_NAME;
            5'd1:  dat_o = 8'h6C;
            5'd2:  dat_o = 8'h6F;
            5'd3:  dat_o = 8'h67;
            5'd4:  dat_o = 8'h49;
            5'd5:  dat_o = 8'h50;
            5'd7:  dat_o = KEY_PROBES;
            5'd11: dat_o = NUM_PROBES;
            5'd12: dat_o = KEY_SMPL_MEM;
            5'd13: dat_o = MEM_BYTES[31:24];
            5'd14: dat_o = MEM_BYTES[23:16];
            5'd15: dat_o = MEM_BYTES[15:8];
            5'd16: dat_o = MEM_BYTES[7:0];
            5'd17: dat_o = KEY_PROTO;
            5'd18: dat_o = PROTO_VER;
            5'd19: dat_o = KEY_END;
            default: dat_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/tx_enc.sv
// SUMP transmit encoder: turns ID/metadata requests and sample
// words into a registered byte stream on a valid/ready link.
module tx_enc
    import tx_enc_pkg::*;
#(
    parameter int MEM_DEPTH = 4096
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        id_i,
    input  logic        rd_meta_i,
    input  logic        smpl_stb_i,
    input  logic [31:0] smpl_i,
    input  logic [3:0]  grp_en_i,
    output logic        rdy_o,
    output logic        tx_stb_o,
    output logic [7:0]  tx_dat_o,
    input  logic        tx_rdy_i
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  mask_q, mask_d;
    logic        stb_q, stb_d;
    logic [7:0]  dat_q, dat_d;

    logic [4:0]  rom_idx;
    logic [7:0]  rom_dat;
    logic [3:0]  src_mask;
    logic [31:0] src_word;
    logic [1:0]  grp_sel;
    logic        grp_hit;
    logic [3:0]  grp_left;
    logic [7:0]  grp_byte;
    logic        xfer;

    assign rdy_o    = (state_q == ST_IDLE);
    assign tx_stb_o = stb_q;
    assign tx_dat_o = dat_q;
    assign xfer     = stb_q & tx_rdy_i;

    // From IDLE the first byte is looked up; otherwise the next one
    assign rom_idx = (state_q == ST_IDLE) ? 5'd0 : idx_q + 5'd1;

    meta_rom #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_meta_rom (
        .idx_i (rom_idx),
        .dat_o (rom_dat)
    );

    // Lowest enabled group in the remaining mask (fresh word when idle)
    always_comb begin
        src_mask = (state_q == ST_IDLE) ? grp_en_i : mask_q;
        src_word = (state_q == ST_IDLE) ? smpl_i : word_q;
        grp_hit  = |src_mask;
        grp_sel  = 2'd0;
        casez (src_mask)
            4'b???1: grp_sel = 2'd0;
            4'b??10: grp_sel = 2'd1;
            4'b?100: grp_sel = 2'd2;
            4'b1000: grp_sel = 2'd3;
            default: grp_sel = 2'd0;
        endcase
        grp_left = src_mask & ~(4'b0001 << grp_sel);
        grp_byte = src_word[{grp_sel, 3'b000} +: 8];
    end

    // Next-state and output byte selection
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        mask_d  = mask_q;
        stb_d   = stb_q;
        dat_d   = dat_q;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = 5'd0;
                if (id_i) begin
                    state_d = ST_ID;
                    stb_d   = 1'b1;
                    dat_d   = id_byte(2'd0);
                end else if (rd_meta_i) begin
                    state_d = ST_META;
                    stb_d   = 1'b1;
                    dat_d   = rom_dat;
                end else if (smpl_stb_i) begin
                    state_d = ST_SMPL;
                    word_d  = smpl_i;
                    mask_d  = grp_left;
                    stb_d   = grp_hit;
                    dat_d   = grp_hit ? grp_byte : 8'h00;
                end
            end
            ST_ID: begin
                if (xfer) begin
                    if (idx_q == ID_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = 5'd0;
                        stb_d   = 1'b0;
                        dat_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        dat_d = id_byte(idx_q[1:0] + 2'd1);
                    end
                end
            end
            ST_META: begin
                if (xfer) begin
                    if (idx_q == META_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = 5'd0;
                        stb_d   = 1'b0;
                        dat_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        dat_d = rom_dat;
                    end
                end
            end
            ST_SMPL: begin
                if (!stb_q || (xfer && !grp_hit)) begin
                    state_d = ST_IDLE;
                    idx_d   = 5'd0;
                    stb_d   = 1'b0;
                    dat_d   = 8'h00;
                end else if (xfer) begin
                    idx_d  = idx_q + 5'd1;
                    mask_d = grp_left;
                    dat_d  = grp_byte;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
                stb_d   = 1'b0;
                dat_d   = 8'h00;
            end
        endcase
    end

    // State and output registers; reset aborts any message
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            word_q  <= 32'd0;
            mask_q  <= 4'd0;
            stb_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            stb_q   <= stb_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: tb/tb_tx_enc.sv
// Randomized scoreboard bench for tx_enc: expected bytes are queued
// at request time and popped by an independent link monitor.
module tb_tx_enc;

    localparam int MEM_DEPTH = 4096;

    logic        clk;
    logic        rst_n;
    logic        id_i;
    logic        rd_meta_i;
    logic        smpl_stb_i;
    logic [31:0] smpl_i;
    logic [3:0]  grp_en_i;
    logic        rdy_o;
    logic        tx_stb_o;
    logic [7:0]  tx_dat_o;
    logic        tx_rdy_i;

    int checks   = 0;
    int failures = 0;
    int nbytes   = 0;
    int rdy_mode = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];

    tx_enc #(
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_in     (rst_n),
        .id_i       (id_i),
        .rd_meta_i  (rd_meta_i),
        .smpl_stb_i (smpl_stb_i),
        .smpl_i     (smpl_i),
        .grp_en_i   (grp_en_i),
        .rdy_o      (rdy_o),
        .tx_stb_o   (tx_stb_o),
        .tx_dat_o   (tx_dat_o),
        .tx_rdy_i   (tx_rdy_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    // Reference model: message contents straight from the protocol
    task automatic push_id();
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'h53);
    endtask

    task automatic push_meta();
        logic [31:0] sz;
        sz = MEM_DEPTH * 4;
        exp_q.push_back(8'h01);
        exp_q.push_back("l");
        exp_q.push_back("o");
        exp_q.push_back("g");
        exp_q.push_back("I");
        exp_q.push_back("P");
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'd32);
        exp_q.push_back(8'h21);
        for (int b = 3; b >= 0; b--)
            exp_q.push_back(8'((sz >> (8 * b)) & 32'hFF));
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
    endtask

    task automatic push_smpl(input logic [31:0] w, input logic [3:0] m);
        for (int g = 0; g < 4; g++)
            if (m[g]) exp_q.push_back(8'((w >> (8 * g)) & 32'hFF));
    endtask

    // Link monitor: pops on every transfer, checks hold during stalls
    initial begin
        logic       hold_pend;
        logic [7:0] hold_dat;
        logic [7:0] e;
        hold_pend = 1'b0;
        hold_dat  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_stb", tx_stb_o, 1);
                    chk("hold_dat", tx_dat_o, hold_dat);
                end
                if (tx_stb_o && tx_rdy_i) begin
                    nbytes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte got=%02h want=none",
                                 tx_dat_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", tx_dat_o, e);
                    end
                end
                hold_pend = tx_stb_o && !tx_rdy_i;
                hold_dat  = tx_dat_o;
            end
        end
    end

    // Sink ready pattern: full rate, one in three, or random
    initial begin
        tx_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: tx_rdy_i = 1'b1;
                1: tx_rdy_i = (cyc % 3 == 0);
                default: tx_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic pulse(input logic id, input logic meta, input logic smp,
                         input logic [31:0] w, input logic [3:0] m,
                         input logic idle);
        @(posedge clk);
        #1;
        chk("rdy_at_req", rdy_o, idle);
        id_i       = id;
        rd_meta_i  = meta;
        smpl_stb_i = smp;
        smpl_i     = w;
        grp_en_i   = m;
        if (idle) begin
            if (id) push_id();
            else if (meta) push_meta();
            else if (smp) push_smpl(w, m);
        end
        @(posedge clk);
        #1;
        id_i       = 1'b0;
        rd_meta_i  = 1'b0;
        smpl_stb_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int base;
        int n;
        logic [31:0] w;
        logic [3:0]  m;
        logic        a, b, c;
        rst_n      = 1'b0;
        id_i       = 1'b0;
        rd_meta_i  = 1'b0;
        smpl_stb_i = 1'b0;
        smpl_i     = 32'd0;
        grp_en_i   = 4'd0;
        #1;
        chk("rst_stb", tx_stb_o, 0);
        chk("rst_dat", tx_dat_o, 0);
        chk("rst_rdy", rdy_o, 1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // ID at full rate with exact latency
        rdy_mode = 0;
        pulse(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("id_stb", tx_stb_o, 1);
        end
        @(negedge clk);
        chk("id_end_stb", tx_stb_o, 0);
        chk("id_end_rdy", rdy_o, 1);
        wait_drain();

        // Metadata with stalls
        rdy_mode = 1;
        pulse(0, 1, 0, 0, 0, 1);
        wait_drain();

        // Sparse mask and empty mask
        rdy_mode = 0;
        pulse(0, 0, 1, 32'hDEADBEEF, 4'b1010, 1);
        wait_drain();
        pulse(0, 0, 1, 32'h12345678, 4'b0000, 1);
        @(negedge clk);
        chk("m0_busy", rdy_o, 0);
        chk("m0_stb", tx_stb_o, 0);
        @(negedge clk);
        chk("m0_rdy", rdy_o, 1);
        chk("m0_stb2", tx_stb_o, 0);

        // Priority, then a metadata request while busy is dropped
        pulse(1, 1, 1, 32'hCAFEF00D, 4'hF, 1);
        pulse(0, 1, 0, 0, 0, 0);
        wait_drain();
        repeat (25) @(negedge clk);
        chk("no_meta_after", rdy_o, 1);

        // Back-to-back full-mask samples
        pulse(0, 0, 1, 32'h03020100, 4'hF, 1);
        wait_drain();
        pulse(0, 0, 1, 32'h07060504, 4'hF, 1);
        wait_drain();

        // Reset in the middle of metadata
        rdy_mode = 1;
        base = nbytes;
        pulse(0, 1, 0, 0, 0, 1);
        n = 0;
        while (nbytes < base + 7 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("meta_progress", 32'(nbytes - base), 7);
        rst_n = 1'b0;
        #1;
        chk("arst_stb", tx_stb_o, 0);
        chk("arst_dat", tx_dat_o, 0);
        chk("arst_rdy", rdy_o, 1);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        rdy_mode = 0;
        pulse(1, 0, 0, 0, 0, 1);
        wait_drain();

        // Randomized traffic
        repeat (40) begin
            rdy_mode = $urandom_range(0, 2);
            w = $urandom();
            m = 4'($urandom_range(0, 15));
            n = $urandom_range(0, 5);
            a = (n == 0);
            b = (n == 1);
            c = (n >= 2);
            if ($urandom_range(0, 3) == 0) begin
                a = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
            end
            pulse(a, b, c, w, m, 1);
            if (exp_q.size() >= 2 && $urandom_range(0, 1) == 1)
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom(), 4'hF, 0);
            wait_drain();
        end

        repeat (5) @(negedge clk);
        chk("final_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
